// File: rtl/alu_status_stage.sv
// Post-ALU pipeline stage: holds the result, keeps NZCV and sticky overflow, evaluates condition codes.
// Optional 8-bit saturating overflow event counter enabled by defining ALU_OVF_COUNT_EN.
module alu_status_stage #(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [N-1:0] result_i,
    input  logic         carry_i,
    input  logic         overflow_i,
    input  logic         flag_we_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [N-1:0] result_o,
    output logic [3:0]   nzcv_o,
    input  logic [3:0]   cond_i,
    output logic         cond_pass_o,
    output logic         ovf_sticky_o,
    input  logic         ovf_clr_i
`ifdef ALU_OVF_COUNT_EN
    ,
    output logic [7:0]   ovf_count_o
`endif
);

    localparam int unsigned CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic         valid_q, valid_d;
    logic [N-1:0] result_q, result_d;
    logic [3:0]   nzcv_q, nzcv_d;
    logic         ovf_sticky_q, ovf_sticky_d;
    logic         accept;
    logic         set_evt;
    logic         cond_base;

    assign ready_o = ~valid_q | ready_i;
    assign accept  = valid_i & ready_o;
    assign set_evt = accept & flag_we_i & overflow_i;

    // Pipeline register, flag and sticky next-state
    always_comb begin
        valid_d      = valid_q;
        result_d     = result_q;
        nzcv_d       = nzcv_q;
        ovf_sticky_d = ovf_sticky_q;
        if (accept) begin
            valid_d  = 1'b1;
            result_d = result_i;
            if (flag_we_i) begin
                nzcv_d = {result_i[N-1], ~|result_i, carry_i, overflow_i};
            end
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
        if (set_evt) begin
            ovf_sticky_d = 1'b1;
        end else if (ovf_clr_i) begin
            ovf_sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            result_q     <= '0;
            nzcv_q       <= 4'b0000;
            ovf_sticky_q <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            result_q     <= result_d;
            nzcv_q       <= nzcv_d;
            ovf_sticky_q <= ovf_sticky_d;
        end
    end

    assign valid_o      = valid_q;
    assign result_o     = result_q;
    assign nzcv_o       = nzcv_q;
    assign ovf_sticky_o = ovf_sticky_q;

`ifdef ALU_OVF_COUNT_EN
    logic [CNT_W-1:0] ovf_count_q, ovf_count_d;

    // Saturating event counter; a set coinciding with clear restarts at one
    always_comb begin
        ovf_count_d = ovf_count_q;
        if (set_evt) begin
            if (ovf_clr_i) begin
                ovf_count_d = CNT_W'(1);
            end else if (ovf_count_q != CNT_MAX) begin
                ovf_count_d = ovf_count_q + CNT_W'(1);
            end
        end else if (ovf_clr_i) begin
            ovf_count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_count_q <= '0;
        end else begin
            ovf_count_q <= ovf_count_d;
        end
    end

    assign ovf_count_o = ovf_count_q;
`endif

    // Condition pairs share a base test; odd codes invert it
    always_comb begin
        cond_base = 1'b0;
        case (cond_i[3:1])
            3'd0: cond_base = nzcv_q[2];
            3'd1: cond_base = nzcv_q[1];
            3'd2: cond_base = nzcv_q[3];
            3'd3: cond_base = nzcv_q[0];
            3'd4: cond_base = nzcv_q[1] & ~nzcv_q[2];
            3'd5: cond_base = (nzcv_q[3] == nzcv_q[0]);
            3'd6: cond_base = ~nzcv_q[2] & (nzcv_q[3] == nzcv_q[0]);
            3'd7: cond_base = 1'b1;
            default: cond_base = 1'b0;
        endcase
    end

    assign cond_pass_o = cond_base ^ cond_i[0];

endmodule

// File: tb/tb_alu_status_stage.sv
// Randomized self-checking bench for alu_status_stage against a cycle-level behavioural model.
module tb_alu_status_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] result_i;
    logic        carry_i;
    logic        overflow_i;
    logic        flag_we_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] result_o;
    logic [3:0]  nzcv_o;
    logic [3:0]  cond_i;
    logic        cond_pass_o;
    logic        ovf_sticky_o;
    logic        ovf_clr_i;
`ifdef ALU_OVF_COUNT_EN
    logic [7:0]  ovf_count_o;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state
    bit          m_valid;
    bit [31:0]   m_res;
    bit [3:0]    m_nzcv;
    bit          m_sticky;
    int          m_count;

    alu_status_stage #(.N(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .result_i     (result_i),
        .carry_i      (carry_i),
        .overflow_i   (overflow_i),
        .flag_we_i    (flag_we_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .result_o     (result_o),
        .nzcv_o       (nzcv_o),
        .cond_i       (cond_i),
        .cond_pass_o  (cond_pass_o),
        .ovf_sticky_o (ovf_sticky_o),
        .ovf_clr_i    (ovf_clr_i)
`ifdef ALU_OVF_COUNT_EN
        ,
        .ovf_count_o  (ovf_count_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit cond_ref(input bit [3:0] cc, input bit [3:0] f);
        bit n, z, c, v;
        {n, z, c, v} = f;
        case (cc)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return c;
            4'h3: return !c;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return c && !z;
            4'h9: return !c || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_valid  = 0;
        m_res    = 0;
        m_nzcv   = 0;
        m_sticky = 0;
        m_count  = 0;
    endtask

    // Drive one cycle of inputs, check outputs mid-cycle, then advance the model at the edge
    task automatic step(input bit rn, input bit v, input bit [31:0] r, input bit c, input bit o,
                        input bit fw, input bit rdy, input bit [3:0] cd, input bit clr);
        bit acc, set;
        rst_n = rn; valid_i = v; result_i = r; carry_i = c; overflow_i = o;
        flag_we_i = fw; ready_i = rdy; cond_i = cd; ovf_clr_i = clr;
        #3;
        check("ready_o", 32'(ready_o), 32'(!m_valid || rdy));
        check("valid_o", 32'(valid_o), 32'(m_valid));
        check("result_o", result_o, m_res);
        check("nzcv_o", 32'(nzcv_o), 32'(m_nzcv));
        check("sticky", 32'(ovf_sticky_o), 32'(m_sticky));
        check("cond_pass", 32'(cond_pass_o), 32'(cond_ref(cd, m_nzcv)));
`ifdef ALU_OVF_COUNT_EN
        check("ovf_count", 32'(ovf_count_o), 32'(m_count));
`endif
        @(posedge clk);
        if (!rn) begin
            model_reset();
        end else begin
            acc = v && (!m_valid || rdy);
            set = acc && fw && o;
            if (acc) begin
                m_valid = 1;
                m_res   = r;
                if (fw) m_nzcv = {r[31], r == 0, c, o};
            end else if (m_valid && rdy) begin
                m_valid = 0;
            end
            if (set) begin
                m_sticky = 1;
                m_count  = clr ? 1 : (m_count < 255 ? m_count + 1 : 255);
            end else if (clr) begin
                m_sticky = 0;
                m_count  = 0;
            end
        end
        #1;
    endtask

    initial begin
        bit [31:0] r;
        rst_n = 0; valid_i = 0; result_i = 0; carry_i = 0; overflow_i = 0;
        flag_we_i = 0; ready_i = 0; cond_i = 0; ovf_clr_i = 0;
        @(posedge clk);
        #1;
        model_reset();

        // Reset then idle
        step(1, 0, 0, 0, 0, 0, 1, 4'h0, 0);
        check("rst_ready", 32'(ready_o), 32'd1);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_nzcv", 32'(nzcv_o), 32'h0);
        check("rst_sticky", 32'(ovf_sticky_o), 32'd0);

        // Zero result with carry
        step(1, 1, 32'h0, 1, 0, 1, 1, 4'h0, 0);
        check("zero_nzcv", 32'(nzcv_o), 32'h6);
        cond_i = 4'h0; #1 check("cond_eq", 32'(cond_pass_o), 32'd1);
        cond_i = 4'h8; #1 check("cond_hi", 32'(cond_pass_o), 32'd0);
        cond_i = 4'h9; #1 check("cond_ls", 32'(cond_pass_o), 32'd1);

        // Negative with overflow, then flag-less accept
        step(1, 1, 32'h8000_0000, 0, 1, 1, 1, 4'hA, 0);
        check("neg_nzcv", 32'(nzcv_o), 32'h9);
        check("neg_sticky", 32'(ovf_sticky_o), 32'd1);
        cond_i = 4'hA; #1 check("cond_ge", 32'(cond_pass_o), 32'd1);
        step(1, 1, 32'h5, 1, 0, 0, 1, 4'hA, 0);
        check("nofw_nzcv", 32'(nzcv_o), 32'h9);
        check("nofw_res", result_o, 32'h5);

        // Backpressure: held, then drain+accept with no bubble
        step(1, 1, 32'h22, 0, 0, 0, 0, 4'h1, 0);
        check("bp_res", result_o, 32'h5);
        check("bp_valid", 32'(valid_o), 32'd1);
        step(1, 1, 32'h33, 0, 0, 0, 1, 4'h1, 0);
        check("nb_res", result_o, 32'h33);
        check("nb_valid", 32'(valid_o), 32'd1);

        // Clear coinciding with a set event
        step(1, 1, 32'h44, 0, 1, 1, 1, 4'h6, 1);
        check("clrset_sticky", 32'(ovf_sticky_o), 32'd1);
`ifdef ALU_OVF_COUNT_EN
        check("clrset_count", 32'(ovf_count_o), 32'd1);
`endif

        // Reset during a stall
        step(1, 1, 32'h55, 0, 0, 0, 0, 4'h0, 0);
        step(0, 1, 32'h66, 1, 1, 1, 1, 4'h0, 0);
        check("mrst_valid", 32'(valid_o), 32'd0);
        check("mrst_res", result_o, 32'h0);
        check("mrst_nzcv", 32'(nzcv_o), 32'h0);
        check("mrst_sticky", 32'(ovf_sticky_o), 32'd0);
        check("mrst_ready", 32'(ready_o), 32'd1);

`ifdef ALU_OVF_COUNT_EN
        check("mrst_count", 32'(ovf_count_o), 32'd0);
        for (int i = 0; i < 260; i++) step(1, 1, 32'(i), 0, 1, 1, 1, 4'h6, 0);
        check("sat_count", 32'(ovf_count_o), 32'd255);
        step(1, 0, 0, 0, 0, 0, 1, 4'h6, 1);
        check("clr_count", 32'(ovf_count_o), 32'd0);
`endif

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            case ($urandom_range(0, 7))
                0: r = 32'h0;
                1: r = 32'h8000_0000 | $urandom();
                default: r = $urandom();
            endcase
            step(($urandom_range(0, 63) != 0), ($urandom_range(0, 3) != 0), r,
                 1'($urandom()), 1'($urandom()), 1'($urandom()),
                 ($urandom_range(0, 3) != 0), 4'($urandom()),
                 ($urandom_range(0, 15) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_status_stage.md
# alu_status_stage

Pipeline stage directly downstream of the ALU. It captures the ALU result together with its carry and overflow flags, and derives N and Z from the captured result. It keeps the architectural NZCV status register, a sticky overflow indicator and an optional overflow event counter. It evaluates a 4-bit condition code against the stored flags for conditional execution in the next stage.

## Interface
- `N`, 32, ALU result width (≥ 2)
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  synchronous reset, active-low
- `valid_i`  in  1  ALU output valid
- `ready_o`  out  1  stage can accept
- `result_i`  in  N  ALU result (Sum)
- `carry_i`  in  1  ALU carry flag
- `overflow_i`  in  1  ALU overflow flag
- `flag_we_i`  in  1  update NZCV with this result (S-bit)
- `valid_o`  out  1  held result valid
- `ready_i`  in  1  downstream accepts
- `result_o`  out  N  held result
- `nzcv_o`  out  4  status register {N,Z,C,V}
- `cond_i`  in  4  condition code to evaluate
- `cond_pass_o`  out  1  condition true on current `nzcv_o`
- `ovf_sticky_o`  out  1  sticky overflow
- `ovf_clr_i`  in  1  clear sticky overflow (and counter)
- `ovf_count_o`  out  8  overflow event count (present only with `ALU_OVF_COUNT_EN`)

## Operation
- Single-entry pipeline register with valid/ready handshake.
  - `ready_o = ~valid_o | ready_i`, combinational.
  - Accept = `valid_i & ready_o`.
- On accept: `result_o <= result_i` and `valid_o <= 1`.
- If `valid_o & ready_i` and there is no accept: `valid_o <= 0`.
- Simultaneous drain and accept: the new result replaces the old one with no bubble, and `valid_o` stays 1.
- No accept: `result_o` holds.
- Flag update occurs only on accept with `flag_we_i = 1`:
  - N = `result_i[N-1]`
  - Z = `~|result_i`
  - C = `carry_i`
  - V = `overflow_i`
- Accept with `flag_we_i = 0` leaves `nzcv_o` unchanged. Flags never change without accept.
- Sticky overflow:
  - Set event = accept & `flag_we_i` & `overflow_i`.
  - Set event → 1; `ovf_clr_i` → 0.
  - Set and clear in the same cycle → 1 (set wins).
- `cond_pass_o` is combinational from the registered `nzcv_o` and `cond_i`:
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C
  - 4 MI N; 5 PL !N; 6 VS V; 7 VC !V
  - 8 HI C&!Z; 9 LS !C|Z
  - A GE N==V; B LT N!=V
  - C GT !Z&(N==V); D LE Z|(N!=V)
  - E AL 1; F NV 0
- Reset (`rst_n = 0` at a rising edge) overrides all other inputs, including an in-flight transfer:
  - `valid_o = 0`, `result_o = 0`, `nzcv_o = 4'b0000`, `ovf_sticky_o = 0`, `ovf_count_o = 0`.
  - `ready_o` reads 1 after reset because `valid_o = 0`.

## Timing
- Latency is 1 cycle: data accepted at edge k appears on `result_o`/`valid_o` after edge k.
- `nzcv_o` updates at the same edge as the accept, so `cond_pass_o` reflects the new flags in cycle k+1.
- Throughput is 1 transfer per cycle while `ready_i = 1`.
- `ready_o` has a combinational path from `ready_i`.
- No other input-to-output combinational paths exist except `cond_i` → `cond_pass_o`.
- `result_o`, `valid_o` and `nzcv_o` are stable while `valid_o & ~ready_i`.

## Configuration
- Macro `ALU_OVF_COUNT_EN`.
- Defined:
  - `ovf_count_o` exists and is an 8-bit counter.
  - It increments on each sticky set event and saturates at 255.
  - `ovf_clr_i` resets it to 0.
  - Clear with a simultaneous set event → 1.
- Undefined: the port and the counter logic are absent. All other behaviour is identical.

## Test plan
- Reset then idle → `valid_o = 0`, `ready_o = 1`, `nzcv_o = 0000`, sticky = 0. Then assert `rst_n = 0` mid-stall with `valid_o = 1` → all outputs return to their reset values at the next edge.
- N=32: accept `result_i = 0x00000000`, carry = 1, overflow = 0, `flag_we_i = 1` → `nzcv_o = 0110`. With `cond_i` = EQ → 1, HI → 0, LS → 1.
- Accept `0x80000000`, overflow = 1, `flag_we_i = 1` → `nzcv_o = 1001`, sticky = 1, GE → 1. Then accept `0x5` with `flag_we_i = 0` → `nzcv_o` stays 1001.
- Backpressure:
  - `ready_i = 0` with `valid_o = 1` → `ready_o = 0`; a new `valid_i` is not accepted and `result_o` holds.
  - Raise `ready_i` with `valid_i = 1` → new result is loaded at the same edge and `valid_o` stays 1.
- `ovf_clr_i` together with a set event → sticky = 1 and, with `ALU_OVF_COUNT_EN`, count = 1.
- With `ALU_OVF_COUNT_EN`: 260 overflow accepts → `ovf_count_o` = 255 (saturated); then `ovf_clr_i` alone → 0.
